pack_ctrl: RTL and testbench

- Counting and sequencing controller for the bottle-filling station.
- Runs on the 1 kHz clock and takes the raw panel buttons plus the hopper drop pulse and the conveyor-stop input.
- Produces the six BCD display digits, the per-digit flicker mask, the beeper mode and the hopper/conveyor enables.
- The top-level display/beeper logic consumes these outputs and maps them to the 7-segment decode, the blanking and the buzzer gating.

---
 rtl/pack_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_pack_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pack_ctrl.sv
// rtl/pack_ctrl.sv - bottle-filling station counter/sequencer; optional PACK_CTRL_DEBOUNCE_EN
module pack_ctrl #(
    parameter int unsigned DEB_MS      = 20,
    parameter int unsigned SWAP_MS     = 2000,
    parameter int unsigned MAX_BOTTLES = 99
) (
    input  logic       clk_1khz,
    input  logic       rst_n,
    input  logic       btn_pulse,
    input  logic       btn_qd,
    input  logic       btn_clr,
    input  logic       hopper_pulse,
    input  logic       conveyor_stop,
    output logic [3:0] digit_1,
    output logic [3:0] digit_2,
    output logic [3:0] digit_3,
    output logic [3:0] digit_4,
    output logic [3:0] digit_5,
    output logic [3:0] digit_6,
    output logic [0:5] flicker_mask,
    output logic [1:0] beep_mode,
    output logic       hopper_en,
    output logic       conveyor_en
);

    localparam int unsigned    TW         = (SWAP_MS > 1) ? $clog2(SWAP_MS) : 1;
    localparam logic [TW-1:0]  TIMER_LOAD = TW'(SWAP_MS - 1);
    localparam logic [7:0]     MAX_BCD    = {4'(MAX_BOTTLES / 10), 4'(MAX_BOTTLES % 10)};

    // Mask bit order: leftmost literal bit is digit_1
    localparam logic [5:0] MASK_SET   = 6'b110000;
    localparam logic [5:0] MASK_RUN   = 6'b000000;
    localparam logic [5:0] MASK_PAUSE = 6'b001100;
    localparam logic [5:0] MASK_END   = 6'b000011;

    localparam logic [1:0] BEEP_OFF  = 2'b00;
    localparam logic [1:0] BEEP_CONT = 2'b01;
    localparam logic [1:0] BEEP_2HZ  = 2'b10;
    localparam logic [1:0] BEEP_4HZ  = 2'b11;

    typedef enum logic [2:0] {
        S_SET,
        S_RUN,
        S_PAUSE,
        S_SWAP,
        S_DONE
    } state_t;

    // Button index: 0 pulse, 1 start/pause, 2 clear
    logic [2:0]    w_btn_raw;
    logic [2:0]    r_btn_s1;
    logic [2:0]    r_btn_s2;
    logic [2:0]    w_btn_lvl;
    logic [2:0]    r_btn_prev;
    logic [2:0]    w_btn_evt;
    logic          r_hop_s1;
    logic          r_hop_s2;
    logic          r_hop_prev;
    logic          w_hop_rise;

    state_t        r_state;
    logic [7:0]    r_target;
    logic [7:0]    r_count;
    logic [7:0]    r_bottles;
    logic [TW-1:0] r_timer;
    logic [5:0]    r_mask;
    logic [1:0]    r_beep;
    logic          r_hop_en;
    logic          r_conv_en;

    logic [7:0]    w_count_inc;
    logic [7:0]    w_bottles_inc;
    logic [7:0]    w_target_inc;
    logic          w_fill_done;
    logic          w_pulse_evt;
    logic          w_qd_evt;
    logic          w_clr_evt;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
            r[7:4] = v[7:4];
        end
        return r;
    endfunction

    assign w_btn_raw = {btn_clr, btn_qd, btn_pulse};

    // Two-flop synchronizers for buttons and hopper, plus edge-detect history
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_s1   <= '0;
            r_btn_s2   <= '0;
            r_btn_prev <= '0;
            r_hop_s1   <= 1'b0;
            r_hop_s2   <= 1'b0;
            r_hop_prev <= 1'b0;
        end else begin
            r_btn_s1   <= w_btn_raw;
            r_btn_s2   <= r_btn_s1;
            r_btn_prev <= w_btn_lvl;
            r_hop_s1   <= hopper_pulse;
            r_hop_s2   <= r_hop_s1;
            r_hop_prev <= r_hop_s2;
        end
    end

`ifdef PACK_CTRL_DEBOUNCE_EN
    localparam int unsigned   DW       = (DEB_MS > 1) ? $clog2(DEB_MS) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_MS - 1);

    logic [DW-1:0] r_deb_cnt [3];
    logic [2:0]    r_deb_lvl;

    // Accept a new level once DEB_MS consecutive samples disagree with the held one
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            r_deb_lvl <= '0;
            for (int i = 0; i < 3; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_btn_s2[i] == r_deb_lvl[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_deb_lvl[i] <= r_btn_s2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_btn_lvl = r_deb_lvl;
`else
    // Debounce time has no meaning when presses come straight from the synchronizer
    if (DEB_MS == 0) begin : g_deb_ms_unused
    end

    assign w_btn_lvl = r_btn_s2;
`endif

    assign w_btn_evt     = w_btn_lvl & ~r_btn_prev;
    assign w_pulse_evt   = w_btn_evt[0];
    assign w_qd_evt      = w_btn_evt[1];
    assign w_clr_evt     = w_btn_evt[2];
    assign w_hop_rise    = r_hop_s2 & ~r_hop_prev;

    assign w_count_inc   = bcd_inc(r_count);
    assign w_bottles_inc = bcd_inc(r_bottles);
    assign w_target_inc  = (r_target == 8'h99) ? 8'h01 : bcd_inc(r_target);
    assign w_fill_done   = w_hop_rise && (w_count_inc == r_target);

    // Station sequencer; outputs are registered alongside every state change
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_SET;
            r_target  <= 8'h10;
            r_count   <= 8'h00;
            r_bottles <= 8'h00;
            r_timer   <= '0;
            r_mask    <= MASK_SET;
            r_beep    <= BEEP_OFF;
            r_hop_en  <= 1'b0;
            r_conv_en <= 1'b0;
        end else if (w_clr_evt) begin
            r_state   <= S_SET;
            r_count   <= 8'h00;
            r_bottles <= 8'h00;
            r_timer   <= '0;
            r_mask    <= MASK_SET;
            r_beep    <= BEEP_OFF;
            r_hop_en  <= 1'b0;
            r_conv_en <= 1'b0;
        end else begin
            case (r_state)
                S_SET: begin
                    if (w_qd_evt) begin
                        r_state  <= S_RUN;
                        r_mask   <= MASK_RUN;
                        r_hop_en <= 1'b1;
                    end else if (w_pulse_evt) begin
                        r_target <= w_target_inc;
                    end
                end
                S_RUN: begin
                    if (w_fill_done) begin
                        r_count   <= 8'h00;
                        r_bottles <= w_bottles_inc;
                        r_hop_en  <= 1'b0;
                        r_mask    <= MASK_END;
                        if (w_bottles_inc == MAX_BCD) begin
                            r_state   <= S_DONE;
                            r_beep    <= BEEP_4HZ;
                            r_conv_en <= 1'b0;
                        end else begin
                            r_state   <= S_SWAP;
                            r_timer   <= TIMER_LOAD;
                            r_beep    <= conveyor_stop ? BEEP_CONT : BEEP_2HZ;
                            r_conv_en <= ~conveyor_stop;
                        end
                    end else begin
                        if (w_hop_rise) begin
                            r_count <= w_count_inc;
                        end
                        if (w_qd_evt) begin
                            r_state  <= S_PAUSE;
                            r_hop_en <= 1'b0;
                            r_mask   <= MASK_PAUSE;
                        end
                    end
                end
                S_PAUSE: begin
                    if (w_qd_evt) begin
                        r_state  <= S_RUN;
                        r_hop_en <= 1'b1;
                        r_mask   <= MASK_RUN;
                    end
                end
                S_SWAP: begin
                    if (conveyor_stop) begin
                        r_conv_en <= 1'b0;
                        r_beep    <= BEEP_CONT;
                    end else if (r_timer == '0) begin
                        r_state   <= S_RUN;
                        r_conv_en <= 1'b0;
                        r_beep    <= BEEP_OFF;
                        r_hop_en  <= 1'b1;
                        r_mask    <= MASK_RUN;
                    end else begin
                        r_timer   <= r_timer - 1'b1;
                        r_conv_en <= 1'b1;
                        r_beep    <= BEEP_2HZ;
                    end
                end
                S_DONE: begin
                end
                default: begin
                    r_state <= S_SET;
                end
            endcase
        end
    end

    assign digit_1      = r_target[7:4];
    assign digit_2      = r_target[3:0];
    assign digit_3      = r_count[7:4];
    assign digit_4      = r_count[3:0];
    assign digit_5      = r_bottles[7:4];
    assign digit_6      = r_bottles[3:0];
    assign flicker_mask = r_mask;
    assign beep_mode    = r_beep;
    assign hopper_en    = r_hop_en;
    assign conveyor_en  = r_conv_en;

endmodule

// File: tb/tb_pack_ctrl.sv
// tb/tb_pack_ctrl.sv - directed self-checking bench for pack_ctrl
`timescale 1ns/1ps
module tb_pack_ctrl;

    localparam int DEB_MS      = 4;
    localparam int SWAP_MS     = 2000;
    localparam int MAX_BOTTLES = 2;
`ifdef PACK_CTRL_DEBOUNCE_EN
    localparam int BTN_LAT = 2 + DEB_MS;
`else
    localparam int BTN_LAT = 2;
`endif

    logic       clk_1khz      = 1'b0;
    logic       rst_n         = 1'b0;
    logic       btn_pulse     = 1'b0;
    logic       btn_qd        = 1'b0;
    logic       btn_clr       = 1'b0;
    logic       hopper_pulse  = 1'b0;
    logic       conveyor_stop = 1'b0;
    logic [3:0] digit_1, digit_2, digit_3, digit_4, digit_5, digit_6;
    logic [0:5] flicker_mask;
    logic [1:0] beep_mode;
    logic       hopper_en;
    logic       conveyor_en;

    logic [23:0] digits;
    logic [5:0]  mask;
    int          n_cmp = 0;
    int          n_bad = 0;

    assign digits = {digit_1, digit_2, digit_3, digit_4, digit_5, digit_6};
    assign mask   = flicker_mask;

    always #5 clk_1khz = ~clk_1khz;

    pack_ctrl #(
        .DEB_MS      (DEB_MS),
        .SWAP_MS     (SWAP_MS),
        .MAX_BOTTLES (MAX_BOTTLES)
    ) u_dut (
        .clk_1khz      (clk_1khz),
        .rst_n         (rst_n),
        .btn_pulse     (btn_pulse),
        .btn_qd        (btn_qd),
        .btn_clr       (btn_clr),
        .hopper_pulse  (hopper_pulse),
        .conveyor_stop (conveyor_stop),
        .digit_1       (digit_1),
        .digit_2       (digit_2),
        .digit_3       (digit_3),
        .digit_4       (digit_4),
        .digit_5       (digit_5),
        .digit_6       (digit_6),
        .flicker_mask  (flicker_mask),
        .beep_mode     (beep_mode),
        .hopper_en     (hopper_en),
        .conveyor_en   (conveyor_en)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_1khz);
    endtask

    task automatic press(input int which);
        case (which)
            0:       btn_pulse = 1'b1;
            1:       btn_qd    = 1'b1;
            default: btn_clr   = 1'b1;
        endcase
        cycles(10);
        btn_pulse = 1'b0;
        btn_qd    = 1'b0;
        btn_clr   = 1'b0;
        cycles(10);
    endtask

    // Returns at the negedge right after the edge where the count updates
    task automatic hop_edge();
        hopper_pulse = 1'b1;
        cycles(2);
        hopper_pulse = 1'b0;
        cycles(1);
    endtask

    task automatic hop();
        hop_edge();
        cycles(2);
    endtask

    task automatic wait_run(input string tag, input int limit);
        int n;
        n = 0;
        while (!hopper_en && n < limit) begin
            n++;
            cycles(1);
        end
        check_eq(tag, {31'd0, hopper_en}, 32'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog timeout");
    end

    initial begin
        int cnt;
        int cnt_conv;

        // Reset values
        cycles(3);
        check_eq("rst_digits", digits, 24'h100000);
        check_eq("rst_mask", mask, 6'b110000);
        check_eq("rst_beep", beep_mode, 2'b00);
        check_eq("rst_hop_en", hopper_en, 1'b0);
        check_eq("rst_conv_en", conveyor_en, 1'b0);
        rst_n = 1'b1;
        cycles(3);

        // Target entry
        for (int i = 0; i < 3; i++) press(0);
        check_eq("set_digits_13", digits, 24'h130000);
        check_eq("set_mask", mask, 6'b110000);
        check_eq("set_beep", beep_mode, 2'b00);

        // Target wrap
        for (int i = 0; i < 86; i++) press(0);
        check_eq("target_99", digits, 24'h990000);
        press(0);
        check_eq("target_wrap_01", digits, 24'h010000);
        for (int i = 0; i < 8; i++) press(0);
        check_eq("target_09", digits, 24'h090000);
        press(0);
        check_eq("target_10", digits, 24'h100000);
        for (int i = 0; i < 92; i++) press(0);
        check_eq("target_03", digits, 24'h030000);

        // Fill and swap
        press(1);
        check_eq("run_hop_en", hopper_en, 1'b1);
        check_eq("run_mask", mask, 6'b000000);
        check_eq("run_beep", beep_mode, 2'b00);
        hop();
        check_eq("count_01", digits, 24'h030100);
        hop();
        check_eq("count_02", digits, 24'h030200);
        hopper_pulse = 1'b1;
        cycles(2);
        check_eq("fill_n1_count", digits, 24'h030200);
        check_eq("fill_n1_conv", conveyor_en, 1'b0);
        hopper_pulse = 1'b0;
        cycles(1);
        check_eq("fill_n2_digits", digits, 24'h030001);
        check_eq("swap_conv_en", conveyor_en, 1'b1);
        check_eq("swap_beep", beep_mode, 2'b10);
        check_eq("swap_mask", mask, 6'b000011);
        check_eq("swap_hop_en", hopper_en, 1'b0);
        cnt = 0;
        while (conveyor_en && cnt < 5000) begin
            cnt++;
            cycles(1);
        end
        check_eq("swap_len", cnt, 2000);
        check_eq("swap_exit_hop_en", hopper_en, 1'b1);
        check_eq("swap_exit_beep", beep_mode, 2'b00);
        check_eq("swap_exit_mask", mask, 6'b000000);

        // Stalled swap
        press(2);
        check_eq("clr_digits", digits, 24'h030000);
        press(1);
        hop();
        hop();
        hop_edge();
        cnt      = 0;
        cnt_conv = 0;
        while (!hopper_en && cnt < 6000) begin
            if (conveyor_en) cnt_conv++;
            if (cnt == 100) conveyor_stop = 1'b1;
            if (cnt == 600) conveyor_stop = 1'b0;
            if (cnt == 101) begin
                check_eq("stall_beep", beep_mode, 2'b01);
                check_eq("stall_conv_en", conveyor_en, 1'b0);
            end
            cnt++;
            cycles(1);
        end
        check_eq("stall_swap_len", cnt, 2500);
        check_eq("stall_conv_cycles", cnt_conv, 2000);

        // Pause
        hop();
        check_eq("pre_pause_count", digits, 24'h030101);
        press(1);
        check_eq("pause_hop_en", hopper_en, 1'b0);
        check_eq("pause_mask", mask, 6'b001100);
        hop();
        hop();
        check_eq("pause_count_held", digits, 24'h030101);
        press(1);
        check_eq("resume_hop_en", hopper_en, 1'b1);
        check_eq("resume_mask", mask, 6'b000000);

        // Finish
        press(2);
        check_eq("clr2_digits", digits, 24'h030000);
        for (int i = 0; i < 97; i++) press(0);
        check_eq("target_01", digits, 24'h010000);
        press(1);
        hop_edge();
        check_eq("fin_swap_digits", digits, 24'h010001);
        wait_run("fin_swap_exit", 3000);
        hop_edge();
        check_eq("done_digits", digits, 24'h010002);
        check_eq("done_beep", beep_mode, 2'b11);
        check_eq("done_mask", mask, 6'b000011);
        check_eq("done_hop_en", hopper_en, 1'b0);
        check_eq("done_conv_en", conveyor_en, 1'b0);
        press(1);
        hop();
        check_eq("done_ignores_qd", beep_mode, 2'b11);
        check_eq("done_ignores_hop", digits, 24'h010002);
        press(2);
        check_eq("done_clr_digits", digits, 24'h010000);
        check_eq("done_clr_mask", mask, 6'b110000);
        check_eq("done_clr_beep", beep_mode, 2'b00);

        // CLR coincident with completing hopper edge
        press(1);
        btn_clr = 1'b1;
        cycles(BTN_LAT - 2);
        hopper_pulse = 1'b1;
        cycles(2);
        hopper_pulse = 1'b0;
        cycles(1);
        check_eq("prio_digits", digits, 24'h010000);
        check_eq("prio_mask", mask, 6'b110000);
        check_eq("prio_conv_en", conveyor_en, 1'b0);
        check_eq("prio_hop_en", hopper_en, 1'b0);
        cycles(4);
        btn_clr = 1'b0;
        cycles(12);

        // Asynchronous reset during swap
        press(1);
        hop_edge();
        cycles(10);
        check_eq("pre_rst_conv_en", conveyor_en, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_digits", digits, 24'h100000);
        check_eq("arst_mask", mask, 6'b110000);
        check_eq("arst_beep", beep_mode, 2'b00);
        check_eq("arst_hop_en", hopper_en, 1'b0);
        check_eq("arst_conv_en", conveyor_en, 1'b0);
        cycles(2);
        rst_n = 1'b1;
        cycles(3);
        check_eq("post_rst_digits", digits, 24'h100000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
